store_buffer: RTL and testbench

//   Write-posting FIFO directly downstream of the core's data-memory port.

---
 rtl/store_buffer.sv | 114 +++++++++++
 tb/tb_store_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: write-posting FIFO between the core's data-memory port and the
// memory/peripheral bus. Every store is captured in the cycle the core issues
// it. Entries drain in order over a valid/ready handshake. Stores that arrive
// while the buffer is full are dropped, and the drop is reported through a
// sticky flag and a saturating counter.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_we,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_data,
  output logic                     bus_valid,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [31:0]              bus_data,
  input  logic                     bus_ready,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE    = 1;
  localparam logic [PTR_W:0]   CNT_ONE    = 1;
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [31:0]       data_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count_q;
  logic [PTR_W:0]    count_next;
  logic              overflow_q;
  logic [15:0]       drop_cnt_q;

  logic              deq;
  logic              enq;
  logic              drop;

  // Status flags all come from the registered occupancy, so they agree with
  // one another in every cycle.
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;

  // A store that arrives while the buffer is full is still accepted when the
  // head leaves in the same cycle. Otherwise the store is dropped.
  assign deq  = bus_valid & bus_ready;
  assign enq  = mem_we & (~full | deq);
  assign drop = mem_we & full & ~deq;

  // The head entry is shown directly on the bus. The output is forced to zero
  // while the buffer is empty. Because of this, stale or never-written storage
  // never reaches the bus.
  assign bus_valid = ~empty;
  assign bus_addr  = empty ? '0 : addr_mem[rd_ptr];
  assign bus_data  = empty ? '0 : data_mem[rd_ptr];

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  // Occupancy next state: count + enq - deq. A simultaneous enq and deq keeps
  // the count unchanged.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    count_next = count_q;
    case ({enq, deq})
      2'b10:   count_next = count_q + CNT_ONE;
      2'b01:   count_next = count_q - CNT_ONE;
      default: count_next = count_q;
    endcase
  end

  // Pointers, occupancy and the overflow bookkeeping. Reset discards
  // everything that is queued.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments. Every register then
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_ONE;
      if (deq) rd_ptr <= rd_ptr + PTR_ONE;
      count_q <= count_next;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  // Entry storage. Only accepted stores are written, so garbage on mem_* while
  // mem_we is low never lands in the buffer.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. Entries are only ever read behind
    // the occupancy count, and the output mux hides them while empty.
    if (!rst && enq) begin
      addr_mem[wr_ptr] <= mem_addr[ADDR_W-1:0];
      data_mem[wr_ptr] <= mem_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer.
// A queue-based reference model tracks what the buffer should hold. Accepted
// stores are pushed onto a scoreboard. A monitor pops the scoreboard on every
// bus handshake. The monitor also checks the status outputs and bus stability
// while the bus is stalled.
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   mem_we;
  logic [31:0]            mem_addr;
  logic [31:0]            mem_data;
  logic                   bus_valid;
  logic [ADDR_W-1:0]      bus_addr;
  logic [31:0]            bus_data;
  logic                   bus_ready;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic [15:0]            drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: contents as a queue, and overflow bookkeeping.
  logic [63:0] m_q[$];
  bit          m_ovf   = 1'b0;
  int          m_drops = 0;
  bit          started = 1'b0;

  // Scoreboard of stores expected on the bus, in order.
  logic [63:0] exp_q[$];

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .bus_valid (bus_valid),
    .bus_addr  (bus_addr),
    .bus_data  (bus_data),
    .bus_ready (bus_ready),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the active edge.
  task automatic step(input logic r, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy);
    rst       = r;
    mem_we    = we;
    mem_addr  = we ? a : $urandom;
    mem_data  = we ? d : $urandom;
    bus_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Reference model, updated with the inputs sampled at each active edge.
  always @(posedge clk) begin
    bit m_deq, m_full, m_enq;
    started = 1'b1;
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      m_full = (m_q.size() == DEPTH);
      m_deq  = (m_q.size() != 0) && bus_ready;
      m_enq  = mem_we && (!m_full || m_deq);
      if (m_deq) void'(m_q.pop_front());
      if (m_enq) begin
        m_q.push_back({mem_addr, mem_data});
        exp_q.push_back({mem_addr, mem_data});
      end
      if (mem_we && m_full && !m_deq) begin
        m_ovf = 1'b1;
        if (m_drops < 16'hFFFF) m_drops++;
      end
    end
  end

  // Monitor, on the inactive edge. It checks status against the model, checks
  // that the bus holds steady while stalled, and pops the scoreboard on every
  // handshake.
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_data;
  always @(negedge clk) begin
    if (started) begin
      check("count",     64'(count),     64'(m_q.size()));
      check("bus_valid", 64'(bus_valid), 64'(m_q.size() != 0));
      check("empty",     64'(empty),     64'(m_q.size() == 0));
      check("full",      64'(full),      64'(m_q.size() == DEPTH));
      check("overflow",  64'(overflow),  64'(m_ovf));
      check("drop_cnt",  64'(drop_cnt),  64'(m_drops));
      if (prev_stall) begin
        check("stall_valid", 64'(bus_valid), 64'd1);
        check("stall_addr",  64'(bus_addr),  64'(prev_addr));
        check("stall_data",  64'(bus_data),  64'(prev_data));
      end
      if (bus_valid && bus_ready && !rst) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bus_entry", {bus_addr, bus_data}, 64'hDEAD_0000_DEAD_0000);
        end else begin
          check("bus_entry", {bus_addr, bus_data}, exp_q.pop_front());
        end
      end
      prev_stall = bus_valid && !bus_ready && !rst;
      prev_addr  = bus_addr;
      prev_data  = bus_data;
    end
  end

  initial begin
    logic [31:0] drain_exp [4];
    int stores;
    int cyc;

    // 1: reset held two cycles with a store request pending.
    step(1'b1, 1'b1, 32'h1234, 32'h5678, 1'b0);
    step(1'b1, 1'b1, 32'h1234, 32'h5678, 1'b0);
    check("rst_count",    64'(count),     64'd0);
    check("rst_valid",    64'(bus_valid), 64'd0);
    check("rst_empty",    64'(empty),     64'd1);
    check("rst_overflow", 64'(overflow),  64'd0);
    check("rst_drop_cnt", 64'(drop_cnt),  64'd0);
    check("rst_bus_addr", 64'(bus_addr),  64'd0);
    check("rst_bus_data", 64'(bus_data),  64'd0);

    // 2: pass-through with bus_ready held high.
    step(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    check("pt_valid", 64'(bus_valid), 64'd1);
    check("pt_addr",  64'(bus_addr),  64'h10);
    check("pt_data",  64'(bus_data),  64'hDEADBEEF);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    check("pt_empty", 64'(empty), 64'd1);

    // 3: fill past capacity under backpressure, then drain.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'(i), 32'hA0 + 32'(i), 1'b0);
    check("fill_full",     64'(full),     64'd1);
    check("fill_count",    64'(count),    64'd4);
    check("fill_overflow", 64'(overflow), 64'd1);
    check("fill_drop_cnt", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", 64'(bus_data), 64'hA0 + 64'(i));
      step(1'b0, 1'b0, 0, 0, 1'b1);
    end
    check("drain_empty", 64'(empty), 64'd1);

    // 4: store issued while full, in the same cycle as a dequeue.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h100 + 32'(i), 32'h50 + 32'(i), 1'b0);
    check("fe_full_before", 64'(full), 64'd1);
    step(1'b0, 1'b1, 32'h200, 32'h55, 1'b1);
    check("fe_count",    64'(count),    64'd4);
    check("fe_drop_cnt", 64'(drop_cnt), 64'd2);
    drain_exp = '{32'h51, 32'h52, 32'h53, 32'h55};
    for (int i = 0; i < 4; i++) begin
      check("fe_order", 64'(bus_data), 64'(drain_exp[i]));
      step(1'b0, 1'b0, 0, 0, 1'b1);
    end
    check("fe_empty", 64'(empty), 64'd1);

    // 5: alternating backpressure, 20 random stores, never overflowing.
    stores = 0;
    cyc    = 0;
    while (stores < 20 && cyc < 500) begin
      if (m_q.size() < DEPTH && ($urandom_range(0, 3) != 0)) begin
        step(1'b0, 1'b1, $urandom, $urandom, cyc[0]);
        stores++;
      end else begin
        step(1'b0, 1'b0, 0, 0, cyc[0]);
      end
      cyc++;
    end
    check("bp_all_issued", 64'(stores), 64'd20);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 0, 0, 1'(i % 2));
    check("bp_no_new_drops", 64'(drop_cnt), 64'd2);
    check("bp_drained",      64'(empty),    64'd1);

    // 6: reset while entries are queued.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h300 + 32'(i), 32'hC0 + 32'(i), 1'b0);
    check("mid_count_before", 64'(count), 64'd3);
    step(1'b1, 1'b1, 32'h3FF, 32'hFF, 1'b0);
    check("mid_valid",    64'(bus_valid), 64'd0);
    check("mid_count",    64'(count),     64'd0);
    check("mid_overflow", 64'(overflow),  64'd0);
    check("mid_drop_cnt", 64'(drop_cnt),  64'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 0, 1'b1);
    check("mid_still_empty", 64'(empty), 64'd1);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
